// File: rtl/rs232_rx_buffer.sv
// Receive byte FIFO behind quick_rs232: stores {err, data} per received byte,
// gives registered reads, sticky overflow and hysteretic rx_ready flow control.
module rs232_rx_buffer #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int HIGH_WATERMARK = 12,
    parameter int LOW_WATERMARK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    input  logic                  in_valid,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clear,
    output logic                  rx_ready
);

    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] HIGH_LVL  = (ADDR_WIDTH+1)'(HIGH_WATERMARK);
    localparam logic [ADDR_WIDTH:0] LOW_LVL   = (ADDR_WIDTH+1)'(LOW_WATERMARK);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } fc_state_t;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_next;
    logic                  wr_ok;
    logic                  rd_ok;
    fc_state_t             state;
    fc_state_t             state_next;

    // Acceptance uses the registered (pre-update) full/empty flags.
    assign wr_ok = in_valid && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        level_next = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_next = level + (ADDR_WIDTH+1)'(1);
            2'b01:   level_next = level - (ADDR_WIDTH+1)'(1);
            default: level_next = level;
        endcase
    end

    // Storage is intentionally not reset; the level counter defines validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {in_err, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            level    <= level_next;
            empty    <= (level_next == '0);
            full     <= (level_next == DEPTH_LVL);
            rd_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                {rd_err, rd_data} <= mem[rd_ptr];
                rd_ptr            <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_READY: if (level_next >= HIGH_LVL) state_next = ST_HOLD;
            ST_HOLD:  if (level_next <= LOW_LVL)  state_next = ST_READY;
            default:  state_next = ST_READY;
        endcase
    end

    assign rx_ready = (state == ST_READY);

endmodule

// File: tb/tb_rs232_rx_buffer.sv
// Bench for rs232_rx_buffer: directed scenarios plus randomized traffic, all
// checked each cycle against a queue-based reference model.
module tb_rs232_rx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HIGH  = 12;
    localparam int LOW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_err;
    logic          in_valid;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clear;
    logic          rx_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW:0]   q[$];
    logic          m_ovf;
    logic          m_ready;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_err;
    logic          m_rd_valid;

    rs232_rx_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .HIGH_WATERMARK(HIGH), .LOW_WATERMARK(LOW)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_err(in_err),
        .in_valid(in_valid), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .ovf_clear(ovf_clear), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf      = 1'b0;
        m_ready    = 1'b1;
        m_rd_data  = '0;
        m_rd_err   = 1'b0;
        m_rd_valid = 1'b0;
    endtask

    task automatic check_all();
        check("level",    32'(level),    32'(q.size()));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("rd_data",  32'(rd_data),  32'(m_rd_data));
        check("rd_err",   32'(rd_err),   32'(m_rd_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rx_ready", 32'(rx_ready), 32'(m_ready));
    endtask

    // One clock of stimulus: update the model from the pre-edge state, drive, check.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic e,
                        input logic r, input logic c);
        logic [DW:0] ent;
        int          n;
        bit          was_full;
        bit          was_empty;
        was_full   = (q.size() == DEPTH);
        was_empty  = (q.size() == 0);
        m_rd_valid = r && !was_empty;
        if (m_rd_valid) begin
            ent       = q.pop_front();
            m_rd_err  = ent[DW];
            m_rd_data = ent[DW-1:0];
        end
        if (v && !was_full) q.push_back({e, d});
        if (v && was_full) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        n = q.size();
        if (m_ready && n >= HIGH)     m_ready = 1'b0;
        else if (!m_ready && n <= LOW) m_ready = 1'b1;

        in_valid  = v;
        in_data   = d;
        in_err    = e;
        rd_en     = r;
        ovf_clear = c;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic e);
        step(1'b1, d, e, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 0; in_data = '0; in_err = 0; rd_en = 0; ovf_clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        idle();

        // Reset while holding 5 bytes
        for (int i = 0; i < 5; i++) wr(8'(i + 8'h30), 1'b0);
        check("pre_rst_level", 32'(level), 32'd5);
        rst = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd();
        check("post_rst_rdv", 32'(rd_valid), 32'd0);

        // Basic write/read with error flag
        wr(8'h55, 1'b0);
        wr(8'hA3, 1'b1);
        wr(8'h0F, 1'b0);
        rd(); check("t2_d0", 32'(rd_data), 32'h55); check("t2_e0", 32'(rd_err), 32'd0);
        rd(); check("t2_d1", 32'(rd_data), 32'hA3); check("t2_e1", 32'(rd_err), 32'd1);
        rd(); check("t2_d2", 32'(rd_data), 32'h0F); check("t2_e2", 32'(rd_err), 32'd0);
        idle(); check("t2_rdv_pulse", 32'(rd_valid), 32'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_level", 32'(level), 32'd16);
        wr(8'hFF, 1'b0);
        check("t3_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd();
            check("t3_drain", 32'(rd_data), 32'(i));
        end
        check("t3_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Hysteresis
        for (int i = 0; i < 12; i++) wr(8'(8'h80 + i), 1'b0);
        check("t4_hold", 32'(rx_ready), 32'd0);
        for (int i = 0; i < 7; i++) rd();
        check("t4_lvl5", 32'(level), 32'd5);
        check("t4_still_hold", 32'(rx_ready), 32'd0);
        rd();
        check("t4_ready", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 4; i++) rd();

        // Pointer wrap with interleaved pairs
        for (int i = 0; i < 40; i++) begin
            wr(8'($urandom), 1'($urandom));
            check("t5_lvl1", 32'(level), 32'd1);
            rd();
            check("t5_empty", 32'(empty), 32'd1);
        end

        // Simultaneous cases
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        check("t6_empty_lvl", 32'(level), 32'd1);
        check("t6_empty_rdv", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 15; i++) wr(8'(i), 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        check("t6_full_lvl", 32'(level), 32'd15);
        check("t6_full_ovf", 32'(overflow), 32'd1);
        wr(8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        check("t6_ovf_prio", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        while (q.size() > 0) rd();

        // Randomized traffic with alternating fill/drain bias
        for (int ph = 0; ph < 16; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 80 : 25;
            for (int k = 0; k < 100; k++) begin
                step(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom),
                     1'($urandom_range(0, 99) < (105 - wp)),
                     1'($urandom_range(0, 99) < 5));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
